// File: rtl/fb_pkg.sv
// Shared constants, state/client types and helpers for the framebuffer memory arbiter.
package fb_pkg;

  localparam int unsigned ADDR_W        = 18;
  localparam int unsigned FB_LINE_WORDS = 160;
  localparam int unsigned FB_WORDS      = FB_LINE_WORDS * 480;

  typedef enum logic [2:0] {
    StIdle,
    StDeAcc,
    StDeCap,
    StVidAcc,
    StVidCap
  } state_e;

  typedef enum logic {
    ClientDe,
    ClientVid
  } client_e;

  // Engine masks mark bytes to skip; the SRAM wants bytes to write.
  function automatic logic [3:0] nbyte_to_be(input logic [3:0] nbyte);
    return ~nbyte;
  endfunction

endpackage

// File: rtl/fb_arb_pick.sv
// Combinational two-way pick between drawing-engine and video requests.
// FB_VID_PRIORITY_EN: video wins every tie; otherwise ties alternate against last_grant.
module fb_arb_pick
  import fb_pkg::*;
(
  input  logic    de_req,
  input  logic    vid_req,
  input  client_e last_grant,
  output logic    grant_de,
  output logic    grant_vid
);

`ifdef FB_VID_PRIORITY_EN
  assign grant_vid = vid_req;
  assign grant_de  = de_req & ~vid_req;
`else
  always_comb begin
    grant_de  = 1'b0;
    grant_vid = 1'b0;
    if (de_req && vid_req) begin
      grant_de  = (last_grant == ClientVid);
      grant_vid = (last_grant == ClientDe);
    end else begin
      grant_de  = de_req;
      grant_vid = vid_req;
    end
  end
`endif

endmodule

// File: rtl/fb_mem_arbiter.sv
// Owns the framebuffer SRAM port, arbitrating drawing-engine and video scan-out accesses.
// Define FB_VID_PRIORITY_EN to give video absolute priority when both clients request.
module fb_mem_arbiter #(
  parameter int unsigned ADDR_W   = fb_pkg::ADDR_W,
  parameter int unsigned FB_WORDS = fb_pkg::FB_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_req,
  output logic              de_ack,
  input  logic [ADDR_W-1:0] de_addr,
  input  logic [3:0]        de_nbyte,
  input  logic              de_rnw,
  input  logic [31:0]       de_w_data,
  output logic [31:0]       de_r_data,
  input  logic              vid_req,
  output logic              vid_ack,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [31:0]       vid_r_data,
  output logic              vid_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  import fb_pkg::*;

  state_e            state_q, state_d;
  client_e           last_q, last_d;
  logic              rd_q, rd_d;
  logic              oor_q, oor_d;
  logic              de_ack_q, de_ack_d;
  logic              vid_ack_q, vid_ack_d;
  logic              vid_valid_q, vid_valid_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       de_r_data_q, de_r_data_d;
  logic [31:0]       vid_r_data_q, vid_r_data_d;

  logic grant_de, grant_vid;
  logic de_in_range, vid_in_range;

  assign de_in_range  = 32'(de_addr) < FB_WORDS;
  assign vid_in_range = 32'(vid_addr) < FB_WORDS;

  fb_arb_pick u_pick (
    .de_req     (de_req),
    .vid_req    (vid_req),
    .last_grant (last_q),
    .grant_de   (grant_de),
    .grant_vid  (grant_vid)
  );

  // Access strobes are computed at the IDLE sample so they appear registered in the ack cycle.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    rd_d         = rd_q;
    oor_d        = oor_q;
    de_ack_d     = 1'b0;
    vid_ack_d    = 1'b0;
    vid_valid_d  = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    de_r_data_d  = de_r_data_q;
    vid_r_data_d = vid_r_data_q;

    unique case (state_q)
      StIdle: begin
        if (grant_de) begin
          state_d     = StDeAcc;
          last_d      = ClientDe;
          rd_d        = de_rnw;
          oor_d       = ~de_in_range;
          de_ack_d    = 1'b1;
          mem_en_d    = de_in_range;
          mem_we_d    = de_in_range & ~de_rnw;
          mem_be_d    = nbyte_to_be(de_nbyte);
          mem_addr_d  = de_addr;
          mem_wdata_d = de_w_data;
        end else if (grant_vid) begin
          state_d    = StVidAcc;
          last_d     = ClientVid;
          oor_d      = ~vid_in_range;
          vid_ack_d  = 1'b1;
          mem_en_d   = vid_in_range;
          mem_be_d   = 4'hF;
          mem_addr_d = vid_addr;
        end
      end
      StDeAcc: begin
        state_d = rd_q ? StDeCap : StIdle;
      end
      StDeCap: begin
        de_r_data_d = oor_q ? 32'h0 : mem_rdata;
        state_d     = StIdle;
      end
      StVidAcc: begin
        state_d = StVidCap;
      end
      StVidCap: begin
        vid_r_data_d = oor_q ? 32'h0 : mem_rdata;
        vid_valid_d  = 1'b1;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_q       <= ClientDe;
      rd_q         <= 1'b0;
      oor_q        <= 1'b0;
      de_ack_q     <= 1'b0;
      vid_ack_q    <= 1'b0;
      vid_valid_q  <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      de_r_data_q  <= 32'h0;
      vid_r_data_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      rd_q         <= rd_d;
      oor_q        <= oor_d;
      de_ack_q     <= de_ack_d;
      vid_ack_q    <= vid_ack_d;
      vid_valid_q  <= vid_valid_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      de_r_data_q  <= de_r_data_d;
      vid_r_data_q <= vid_r_data_d;
    end
  end

  assign de_ack     = de_ack_q;
  assign vid_ack    = vid_ack_q;
  assign vid_valid  = vid_valid_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign de_r_data  = de_r_data_q;
  assign vid_r_data = vid_r_data_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench for fb_mem_arbiter: SRAM model, engine/video clients and a monitor.
module tb_fb_mem_arbiter;
  import fb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              de_req, de_ack, de_rnw;
  logic [ADDR_W-1:0] de_addr;
  logic [3:0]        de_nbyte;
  logic [31:0]       de_w_data, de_r_data;
  logic              vid_req, vid_ack, vid_valid;
  logic [ADDR_W-1:0] vid_addr;
  logic [31:0]       vid_r_data;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  typedef struct {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        nbyte;
    logic [31:0]       wdata;
    logic [31:0]       rdexp;
  } de_item_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       exp;
  } vid_item_t;

  de_item_t    de_q[$];
  vid_item_t   vid_q[$];
  logic [31:0] sram[int];
  logic [31:0] ref_mem[int];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        sb_off = 1'b1;
  logic [31:0] held_init = 32'h0;
  logic [31:0] held_exp;

  always #5 clk = ~clk;

  fb_mem_arbiter u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .de_req     (de_req),
    .de_ack     (de_ack),
    .de_addr    (de_addr),
    .de_nbyte   (de_nbyte),
    .de_rnw     (de_rnw),
    .de_w_data  (de_w_data),
    .de_r_data  (de_r_data),
    .vid_req    (vid_req),
    .vid_ack    (vid_ack),
    .vid_addr   (vid_addr),
    .vid_r_data (vid_r_data),
    .vid_valid  (vid_valid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] init_val(input int a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] sram_read(input int a);
    return sram.exists(a) ? sram[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic in_fb(input logic [ADDR_W-1:0] a);
    return 32'(a) < FB_WORDS;
  endfunction

  function automatic void ref_write(input logic [ADDR_W-1:0] a, input logic [3:0] nbyte,
                                    input logic [31:0] wd);
    logic [31:0] w;
    if (!in_fb(a)) return;
    w = ref_read(int'(a));
    for (int b = 0; b < 4; b++) if (!nbyte[b]) w[8*b +: 8] = wd[8*b +: 8];
    ref_mem[int'(a)] = w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // SRAM: read data valid the cycle after mem_en
  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_en) begin
      w = sram_read(int'(mem_addr));
      mem_rdata <= w;
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        sram[int'(mem_addr)] = w;
      end
    end
  end

  task automatic de_op(input logic rnw, input logic [ADDR_W-1:0] addr, input logic [3:0] nbyte,
                       input logic [31:0] wdata, output logic [31:0] rdata);
    de_item_t it;
    int n = 0;
    it.rnw   = rnw;
    it.addr  = addr;
    it.nbyte = nbyte;
    it.wdata = wdata;
    it.rdexp = (rnw && in_fb(addr)) ? ref_read(int'(addr)) : 32'h0;
    if (!rnw) ref_write(addr, nbyte, wdata);
    de_q.push_back(it);
    de_rnw = rnw; de_addr = addr; de_nbyte = nbyte; de_w_data = wdata; de_req = 1'b1;
    do begin @(negedge clk); n++; end while (!de_ack && n < 100);
    chk("de_ack_seen", de_ack, 1);
    de_req = 1'b0;
    if (!de_ack) void'(de_q.pop_back());
    @(negedge clk);
    rdata = 32'h0;
    if (rnw) begin
      @(negedge clk);
      rdata = de_r_data;
    end
  endtask

  task automatic vid_op(input logic [ADDR_W-1:0] addr);
    vid_item_t it;
    int n = 0;
    it.addr = addr;
    it.exp  = in_fb(addr) ? ref_read(int'(addr)) : 32'h0;
    vid_q.push_back(it);
    vid_addr = addr; vid_req = 1'b1;
    do begin @(negedge clk); n++; end while (!vid_ack && n < 100);
    chk("vid_ack_seen", vid_ack, 1);
    vid_req = 1'b0;
    if (!vid_ack) void'(vid_q.pop_back());
    repeat (2) @(negedge clk);
  endtask

  initial begin : monitor
    de_item_t    d;
    vid_item_t   v;
    int          pend;
    int          vcnt;
    logic [31:0] pend_val;
    logic [31:0] vexp;
    logic        prev_de_ack;
    logic        vid_due;
    logic        inr;
    pend = 0; vcnt = 0; pend_val = '0; vexp = '0; prev_de_ack = 1'b0; held_exp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || sb_off) begin
        pend = 0; vcnt = 0; prev_de_ack = 1'b0; held_exp = held_init;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) held_exp = pend_val;
        end
        chk("de_r_data", de_r_data, held_exp);
        vid_due = 1'b0;
        if (vcnt > 0) begin
          vcnt--;
          vid_due = (vcnt == 0);
        end
        if (vid_valid || vid_due) begin
          chk("vid_valid_timing", vid_valid, vid_due);
          if (vid_valid && vid_due) chk("vid_r_data", vid_r_data, vexp);
        end
        if (mem_en) chk("mem_en_only_on_ack", de_ack | vid_ack, 1);
        if (de_ack) begin
          chk("de_ack_single", prev_de_ack, 0);
          chk("ack_exclusive", vid_ack, 0);
          chk("de_ack_has_item", 32'(de_q.size() > 0), 1);
          if (de_q.size() > 0) begin
            d   = de_q.pop_front();
            inr = in_fb(d.addr);
            chk("de_mem_en", mem_en, inr);
            chk("de_mem_be", mem_be, 4'(~d.nbyte));
            if (inr) begin
              chk("de_mem_we", mem_we, !d.rnw);
              chk("de_mem_addr", mem_addr, d.addr);
            end
            if (inr && !d.rnw) chk("de_mem_wdata", mem_wdata, d.wdata);
            if (d.rnw) begin
              pend = 2; pend_val = d.rdexp;
            end
          end
        end
        prev_de_ack = de_ack;
        if (vid_ack) begin
          chk("vid_ack_has_item", 32'(vid_q.size() > 0), 1);
          if (vid_q.size() > 0) begin
            v   = vid_q.pop_front();
            inr = in_fb(v.addr);
            chk("vid_mem_en", mem_en, inr);
            chk("vid_mem_we", mem_we, 0);
            chk("vid_mem_be", mem_be, 4'hF);
            if (inr) chk("vid_mem_addr", mem_addr, v.addr);
            vcnt = 2; vexp = v.exp;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int                n;
    int                grants_de;
    int                bad;
    logic [31:0]       rd, rd2, tmp, expw;
    logic [31:0]       exp_rmw[4];
    client_e           log_q[$];
    client_e           expc;
    logic              drnw;
    logic [ADDR_W-1:0] da, va;

    rst_n = 1'b0; de_req = 1'b0; vid_req = 1'b0; de_rnw = 1'b0; de_addr = '0;
    de_nbyte = 4'h0; de_w_data = 32'h0; vid_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_de_ack", de_ack, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_de_r_data", de_r_data, 0);
    chk("rst_vid_valid", vid_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset pulsed while a read is in its ack cycle
    de_rnw = 1'b1; de_addr = ADDR_W'(32'h10); de_nbyte = 4'h0; de_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!de_ack && n < 20);
    chk("midrd_ack", de_ack, 1);
    rst_n = 1'b0;
    #1;
    chk("midrd_rst_de_ack", de_ack, 0);
    chk("midrd_rst_mem_en", mem_en, 0);
    chk("midrd_rst_mem_addr", 32'(mem_addr), 0);
    chk("midrd_rst_mem_be", mem_be, 0);
    de_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrd_no_update", de_r_data, 0);

    // Both requests held from reset
    de_rnw = 1'b1; de_addr = ADDR_W'(32'h5); vid_addr = ADDR_W'(32'h10005);
    de_req = 1'b1; vid_req = 1'b1;
    for (int c = 0; c < 80 && log_q.size() < 4; c++) begin
      @(negedge clk);
      if (vid_ack) log_q.push_back(ClientVid);
      if (de_ack) log_q.push_back(ClientDe);
    end
    de_req = 1'b0; vid_req = 1'b0;
    chk("tie_grant_count", log_q.size(), 4);
    grants_de = 0;
    for (int i = 0; i < log_q.size(); i++) begin
`ifdef FB_VID_PRIORITY_EN
      expc = ClientVid;
`else
      expc = (i % 2 == 0) ? ClientVid : ClientDe;
`endif
      chk($sformatf("tie_grant_%0d", i), log_q[i], expc);
      if (log_q[i] == ClientDe) grants_de++;
    end
    repeat (4) @(negedge clk);
    held_init = (grants_de > 0) ? ref_read(5) : 32'h0;
    @(negedge clk);
    sb_off = 1'b0;

    // Directed engine accesses
    tmp = init_val(32'h50);
    de_op(1'b0, ADDR_W'(32'h50), 4'b1000, 32'hAABBCCDD, rd);
    expw = {tmp[31:24], 24'hBBCCDD};
    chk("wr_byte3_kept", sram_read(32'h50), expw);
    de_op(1'b0, ADDR_W'(32'hA0), 4'h0, 32'h12345678, rd);
    de_op(1'b1, ADDR_W'(32'hA0), 4'h0, 32'h0, rd);
    chk("raw_rd", rd, 32'h12345678);
    repeat (3) @(negedge clk);
    de_op(1'b1, ADDR_W'(32'h12C00), 4'h0, 32'h0, rd);
    chk("oor_rd_zero", rd, 32'h0);
    de_op(1'b0, ADDR_W'(32'h12C00), 4'h0, 32'hDEADBEEF, rd);
    chk("oor_wr_dropped", 32'(sram.exists(76800)), 0);
    de_op(1'b0, ADDR_W'(32'h60), 4'hF, 32'hFFFF0000, rd);
    chk("nbyte_f_noop", sram_read(32'h60), init_val(32'h60));
    vid_op(ADDR_W'(32'h10020));
    vid_op(ADDR_W'(32'h12C00));

    // Engine read-modify-write of words 0..3
    for (int i = 0; i < 4; i++) exp_rmw[i] = (ref_read(i) & 32'hF0F0FF00) ^ 32'h01234567;
    for (int i = 0; i < 4; i++) begin
      de_op(1'b1, ADDR_W'(i), 4'h0, 32'h0, rd);
      de_op(1'b0, ADDR_W'(i), 4'h0, (rd & 32'hF0F0FF00) ^ 32'h01234567, rd2);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rmw_word_%0d", i), sram_read(i), exp_rmw[i]);

    // Random concurrent traffic; video reads stay out of the engine's address range
    fork
      begin
        for (int k = 0; k < 120; k++) begin
          drnw = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 9) == 0) da = ADDR_W'(FB_WORDS + $urandom_range(0, 185343));
          else da = ADDR_W'($urandom_range(0, 32'hFFFF));
          de_op(drnw, da, 4'($urandom), $urandom, rd);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 80; k++) begin
          if ($urandom_range(0, 9) == 0) va = ADDR_W'(FB_WORDS + $urandom_range(0, 185343));
          else va = ADDR_W'(32'h10000 + $urandom_range(0, 32'h2BFF));
          vid_op(va);
          repeat ($urandom_range(0, 4)) @(negedge clk);
        end
      end
    join

    repeat (6) @(negedge clk);
    chk("de_q_drained", de_q.size(), 0);
    chk("vid_q_drained", vid_q.size(), 0);
    bad = 0;
    foreach (sram[a]) if (sram[a] !== ref_read(a)) bad++;
    foreach (ref_mem[a]) if (ref_mem[a] !== sram_read(a)) bad++;
    chk("mem_image", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
Downstream stage of the drawing engines. Owns the framebuffer SRAM port and arbitrates between the drawing-engine bus (de_*) and a video scan-out read port (vid_*). Converts de_nbyte write masks to SRAM byte enables and returns read data with the timing the engines' REQ→ACK→DATA sequence expects. The framebuffer is 640x480 8-bit pixels, stored as 160 words per line.

Parameters:
ADDR_W, 18, word address width on all ports
FB_WORDS, 76800, number of valid framebuffer words (addresses 0..FB_WORDS-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
de_req  in  1  drawing-engine request, level, held until de_ack
de_ack  out  1  one-cycle grant pulse, registered
de_addr  in  ADDR_W  word address, stable while de_req high
de_nbyte  in  4  byte mask, 1 = do not write that byte (writes only)
de_rnw  in  1  1 = read, 0 = write
de_w_data  in  32  write data
de_r_data  out  32  read data, registered, held until the next de read completes
vid_req  in  1  scan-out read request, level, held until vid_ack
vid_ack  out  1  one-cycle grant pulse, registered
vid_addr  in  ADDR_W  scan-out word address
vid_r_data  out  32  scan-out read data, registered
vid_valid  out  1  one-cycle pulse when vid_r_data updates
mem_en  out  1  SRAM access strobe, registered
mem_we  out  1  SRAM write strobe, registered
mem_be  out  4  SRAM byte enables, active high
mem_addr  out  ADDR_W  SRAM word address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data, valid the cycle after mem_en

Behaviour:
- Reset (async, rst_n low): state IDLE; de_ack, vid_ack, vid_valid, mem_en, mem_we = 0; mem_be, mem_addr, mem_wdata, de_r_data, vid_r_data = 0; last_grant = DE. Any in-flight access is abandoned with no ack or valid.
- States: IDLE, DE_ACC, DE_CAP, VID_ACC, VID_CAP.
- IDLE: sample requests at the clock edge.
  - Only de_req → DE_ACC.
  - Only vid_req → VID_ACC.
  - Both → grant the client that is not last_grant (round robin).
  - Neither → stay in IDLE.
- DE_ACC, one cycle:
  - de_ack = 1; mem_en = 1; mem_addr = de_addr; mem_we = ~de_rnw; mem_be = ~de_nbyte; mem_wdata = de_w_data; last_grant ← DE.
  - Next state: DE_CAP if read, else IDLE.
- DE_CAP: de_r_data ← mem_rdata at the end of this cycle, then IDLE. Read data is valid from the second cycle after the de_ack cycle, onward.
- VID_ACC: vid_ack = 1; read with mem_be = 4'hF; last_grant ← VID; next state VID_CAP.
- VID_CAP: vid_r_data ← mem_rdata; vid_valid = 1 in the following cycle; then IDLE.
- Requests are ignored in the ack cycle and the cycle after it. This guards against a client's req still being high while it sees its own ack.
- Minimum spacing: write 2 cycles (sample to ack); read 3 cycles (sample to capture).
- Out of range (addr >= FB_WORDS):
  - Access is still acked.
  - mem_en = 0, so no SRAM cycle.
  - Reads return 32'h0 with the same latency; writes are dropped.
- mem_be for de_nbyte = 4'hF is 4'h0: a legal no-op write with mem_en = 1 and mem_we = 1.
- Request deasserted before ack: a protocol violation. The arbiter latches no request state between cycles; whatever is present at the IDLE sample is used.

Optional Feature:
FB_VID_PRIORITY_EN:
- Defined: vid_req always wins ties and last_grant is ignored. Worst-case video wait is one DE read (3 cycles).
- Undefined: round robin as above. Worst-case video wait is one DE access plus its own.

Decomposition:
- Package fb_pkg: FB_LINE_WORDS = 160, FB_WORDS = 76800, ADDR_W, state enum, client enum {DE, VID}, and function nbyte_to_be (bitwise invert).
- One natural sub-module: fb_arb_pick. Combinational 2-way pick from req pair, last_grant and the priority macro; outputs grant_de and grant_vid.

Test Plan:
- Reset mid-read: de_req read at 0x00010, rst_n pulsed low during DE_ACC → all outputs 0 immediately; no de_r_data update; IDLE after release.
- DE write: addr 0x00050, nbyte 4'b1000, data 0xAABBCCDD → one de_ack pulse; mem_we = 1; mem_be = 4'b0111; SRAM byte3 unchanged.
- DE read-after-write: write 0x12345678 to 0x00A0, then read 0x00A0 → de_r_data = 0x12345678 from ack+2 and held until the next read.
- Simultaneous: de_req and vid_req held together from reset, 4 grants → order VID, DE, VID, DE. With FB_VID_PRIORITY_EN → all VID while vid_req stays high.
- Out of range: read 0x12C00 (76800) → ack issued, mem_en stays 0, de_r_data = 0. Write to the same address → SRAM unchanged.
- Back-to-back engine sequence: emulate REQ/ACK/DATA/WREQ for 4 words at 0x0000..0x0003 with the AND/XOR colour update → all 4 words read-modify-written correctly, no double acks.
